comparator_scan_sequencer: RTL and testbench
============================================

Name: comparator_scan_sequencer

Overview:
- Upstream controller for comparator_injector.
- Sweeps a one-hot expected halfstrip pattern across a configurable strip range. For each strip it clears the injector's error counters, fires N pulses through the injector's fire_pulse/pulser_ready handshake, then reports the accumulated error counts as one result word.
- Sits between the slow-control register block and comparator_injector.

Parameters:
- NSTRIPS, 32, width of halfstrip vector; strip index width is clog2(NSTRIPS)=5.
- CNT_W, 16, width of pulse count and reported error counts.
- TIMEOUT, 255, max cycles waited for any pulser_ready edge before aborting.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins scan when idle
- abort  in  1  level; terminates scan at next state boundary
- num_pulses  in  CNT_W  pulses per strip; 0 treated as 1
- first_strip  in  5  first strip index
- last_strip  in  5  last strip index, inclusive
- inject_en  in  1  requested compin injection
- pulser_ready  in  1  from injector
- halfstrips_errcnt  in  32  from injector
- compout_errcnt  in  32  from injector
- fire_pulse  out  1  to injector
- halfstrips_expect  out  NSTRIPS  one-hot (1 << cur_strip)
- compout_expect  out  1  equals latched inject_en
- compin_inject  out  1  equals latched inject_en
- halfstrips_errcnt_rst  out  1  to injector
- compout_errcnt_rst  out  1  to injector
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at scan end
- timeout_err  out  1  sticky; cleared by start or rst
- result_valid  out  1  one-cycle pulse per strip
- result_strip  out  5  strip index of result
- result_hs_errs  out  CNT_W  saturated halfstrips_errcnt
- result_co_errs  out  CNT_W  saturated compout_errcnt

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- All outputs are registered.
- Start latch: on start in IDLE, latch first_strip, last_strip, num_pulses and inject_en.
  - If first_strip > last_strip, the scan covers first_strip only.
  - start while busy is ignored.
- States:
  - IDLE -> CLR on start.
  - CLR: assert both errcnt_rst for exactly 1 cycle; pulse_cnt <= 0; -> ARM.
  - ARM: wait for pulser_ready=1 (timer runs); -> FIRE.
  - FIRE: fire_pulse=1 for exactly 1 cycle; -> WAIT_ACK.
  - WAIT_ACK: wait for pulser_ready=0 (injector left idle); -> WAIT_DONE.
  - WAIT_DONE: wait for pulser_ready=1; pulse_cnt++.
    - If pulse_cnt+1 < eff_num -> FIRE.
    - Else -> SETTLE.
  - SETTLE: 1 cycle so the counter written in the injector's readout cycle is stable; -> REPORT.
  - REPORT: sample counters; result_valid=1 for 1 cycle.
    - If cur_strip == last or single-strip -> DONE.
    - Else cur_strip++ -> CLR.
  - DONE: done=1 for 1 cycle; -> IDLE.
- Timeout: timer resets on every state entry and increments in ARM/WAIT_ACK/WAIT_DONE. On reaching TIMEOUT: timeout_err<=1, fire_pulse=0, go to DONE with no result for the current strip.
- abort: checked in CLR, ARM and REPORT (after emitting the result). Goes to DONE. It never interrupts an outstanding pulse.
- Saturation: a result field equals 2^CNT_W-1 if the 32-bit count ≥ that value, else the low CNT_W bits.
- Output timing:
  - halfstrips_expect updates on entry to CLR and is stable for the whole strip.
  - compout_expect and compin_inject are stable for the whole scan.
- Strip index never wraps: last_strip=31 terminates the scan, no increment past 31.
- rst mid-scan: immediate IDLE, all outputs 0. The injector may still complete its pulse; its pulser_ready rising is ignored.

Decomposition:
- Shared package comptest_pkg:
  - state enum (IDLE, CLR, ARM, FIRE, WAIT_ACK, WAIT_DONE, SETTLE, REPORT, DONE);
  - NSTRIPS, STRIP_W, CNT_W constants;
  - saturate function.
- One natural sub-module: scan_timeout_timer (load/enable/expired). Everything else is inline.

Test Plan:
- Single strip: first=last=5, num_pulses=3, injector model with 7-cycle pulse and errcnt returning 2 -> exactly 3 fire_pulse pulses, halfstrips_expect=32'h00000020, one result_valid with strip=5, hs_errs=2; done 1 cycle later.
- Sweep: first=0, last=3, num_pulses=1 -> 4 results with strips 0,1,2,3 in order; an errcnt_rst pulse precedes each strip's first fire_pulse.
- Boundaries:
  - num_pulses=0 -> 1 pulse per strip.
  - first=10, last=4 -> single result, strip 10.
  - last=31 -> ends without wrap.
- Saturation: model returns halfstrips_errcnt=32'h00012345 -> result_hs_errs=16'hFFFF; compout_errcnt=7 -> result_co_errs=7.
- Timeout: pulser_ready held low after fire -> timeout_err=1 after 255 cycles, done pulse, no result_valid; the next start clears timeout_err.
- Abort and reset:
  - abort asserted during WAIT_DONE of strip 2 -> strip 2 result is still emitted, then done.
  - start while busy -> ignored.
  - rst mid-WAIT_ACK -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/comptest_pkg.sv
// ============================================================================
// Module      : comptest_pkg
// Description : Shared constants, scan-state encoding and count saturation
// Revision    : 1.0
// ============================================================================
`default_nettype none

package comptest_pkg;

    localparam int NSTRIPS = 32;
    localparam int STRIP_W = $clog2(NSTRIPS);
    localparam int CNT_W   = 16;
    localparam int ERR_W   = 32;

    typedef logic [3:0] state_t;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_CLR       = 4'd1;
    localparam logic [3:0] ST_ARM       = 4'd2;
    localparam logic [3:0] ST_FIRE      = 4'd3;
    localparam logic [3:0] ST_WAIT_ACK  = 4'd4;
    localparam logic [3:0] ST_WAIT_DONE = 4'd5;
    localparam logic [3:0] ST_SETTLE    = 4'd6;
    localparam logic [3:0] ST_REPORT    = 4'd7;
    localparam logic [3:0] ST_DONE      = 4'd8;

    // Any set bit above the reported width means the count is at least all-ones.
    function automatic logic [CNT_W-1:0] saturate(input logic [ERR_W-1:0] v);
        if (|v[ERR_W-1:CNT_W]) begin
            return {CNT_W{1'b1}};
        end
        return v[CNT_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_timeout_timer.sv
// ============================================================================
// Module      : scan_timeout_timer
// Description : Wait-state watchdog; cleared on load, counts while enabled
// Revision    : 1.0
// ============================================================================
`default_nettype none

module scan_timeout_timer #(
    parameter int TIMEOUT = 255,
    parameter int W       = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == W'(TIMEOUT));

endmodule

`default_nettype wire

// File: rtl/comparator_scan_sequencer.sv
// ============================================================================
// Module      : comparator_scan_sequencer
// Description : Sweeps a one-hot halfstrip pattern through comparator_injector
// Revision    : 1.0
// ============================================================================
`default_nettype none

module comparator_scan_sequencer
    import comptest_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     num_pulses,
    input  logic [STRIP_W-1:0]   first_strip,
    input  logic [STRIP_W-1:0]   last_strip,
    input  logic                 inject_en,
    input  logic                 pulser_ready,
    input  logic [ERR_W-1:0]     halfstrips_errcnt,
    input  logic [ERR_W-1:0]     compout_errcnt,
    output logic                 fire_pulse,
    output logic [NSTRIPS-1:0]   halfstrips_expect,
    output logic                 compout_expect,
    output logic                 compin_inject,
    output logic                 halfstrips_errcnt_rst,
    output logic                 compout_errcnt_rst,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic                 result_valid,
    output logic [STRIP_W-1:0]   result_strip,
    output logic [CNT_W-1:0]     result_hs_errs,
    output logic [CNT_W-1:0]     result_co_errs
);

    state_t               r_state;
    state_t               w_next;
    logic                 w_timeout;
    logic                 w_expired;
    logic                 w_tmr_en;
    logic                 w_more;
    logic [STRIP_W-1:0]   w_clr_strip;

    logic [STRIP_W-1:0]   r_cur_strip;
    logic [STRIP_W-1:0]   r_last_strip;
    logic                 r_single;
    logic [CNT_W-1:0]     r_eff_num;
    logic [CNT_W-1:0]     r_pulse_cnt;
    logic                 r_inject;
    logic                 r_fire;
    logic                 r_errcnt_rst;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_timeout_err;
    logic                 r_result_valid;
    logic [NSTRIPS-1:0]   r_hs_expect;
    logic [STRIP_W-1:0]   r_result_strip;
    logic [CNT_W-1:0]     r_result_hs;
    logic [CNT_W-1:0]     r_result_co;

    assign w_tmr_en    = (r_state == ST_ARM) || (r_state == ST_WAIT_ACK) || (r_state == ST_WAIT_DONE);
    assign w_more      = ({1'b0, r_pulse_cnt} + 1'b1) < {1'b0, r_eff_num};
    assign w_clr_strip = (r_state == ST_IDLE) ? first_strip : r_cur_strip + STRIP_W'(1);

    scan_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_next != r_state),
        .i_en      (w_tmr_en),
        .o_expired (w_expired)
    );

    // A satisfied wait condition takes priority over a timer expiring the same cycle.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE:      if (start) w_next = ST_CLR;
            ST_CLR:       w_next = abort ? ST_DONE : ST_ARM;
            ST_ARM: begin
                if (abort) begin
                    w_next = ST_DONE;
                end else if (pulser_ready) begin
                    w_next = ST_FIRE;
                end else if (w_expired) begin
                    w_next    = ST_DONE;
                    w_timeout = 1'b1;
                end
            end
            ST_FIRE:      w_next = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (!pulser_ready) begin
                    w_next = ST_WAIT_DONE;
                end else if (w_expired) begin
                    w_next    = ST_DONE;
                    w_timeout = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (pulser_ready) begin
                    w_next = w_more ? ST_FIRE : ST_SETTLE;
                end else if (w_expired) begin
                    w_next    = ST_DONE;
                    w_timeout = 1'b1;
                end
            end
            ST_SETTLE:    w_next = ST_REPORT;
            ST_REPORT:    w_next = (abort || r_single || (r_cur_strip == r_last_strip)) ? ST_DONE : ST_CLR;
            ST_DONE:      w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cur_strip    <= '0;
            r_last_strip   <= '0;
            r_single       <= 1'b0;
            r_eff_num      <= '0;
            r_pulse_cnt    <= '0;
            r_inject       <= 1'b0;
            r_fire         <= 1'b0;
            r_errcnt_rst   <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_result_valid <= 1'b0;
            r_hs_expect    <= '0;
            r_result_strip <= '0;
            r_result_hs    <= '0;
            r_result_co    <= '0;
        end else begin
            r_state        <= w_next;
            r_fire         <= (w_next == ST_FIRE);
            r_errcnt_rst   <= (w_next == ST_CLR);
            r_done         <= (w_next == ST_DONE);
            r_busy         <= (w_next != ST_IDLE);
            r_result_valid <= (w_next == ST_REPORT);

            if (r_state == ST_IDLE && start) begin
                r_last_strip  <= last_strip;
                r_single      <= (first_strip > last_strip);
                r_eff_num     <= (num_pulses == '0) ? CNT_W'(1) : num_pulses;
                r_inject      <= inject_en;
                r_timeout_err <= 1'b0;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end

            if (w_next == ST_CLR) begin
                r_cur_strip <= w_clr_strip;
                r_hs_expect <= NSTRIPS'(1) << w_clr_strip;
            end else if (w_next == ST_IDLE) begin
                r_hs_expect <= '0;
                r_inject    <= 1'b0;
            end

            if (r_state == ST_CLR) begin
                r_pulse_cnt <= '0;
            end else if (r_state == ST_WAIT_DONE && pulser_ready) begin
                r_pulse_cnt <= r_pulse_cnt + 1'b1;
            end

            // Sampled at the end of SETTLE so the injector's last write has landed.
            if (w_next == ST_REPORT) begin
                r_result_strip <= r_cur_strip;
                r_result_hs    <= saturate(halfstrips_errcnt);
                r_result_co    <= saturate(compout_errcnt);
            end
        end
    end

    assign fire_pulse            = r_fire;
    assign halfstrips_expect     = r_hs_expect;
    assign compout_expect        = r_inject;
    assign compin_inject         = r_inject;
    assign halfstrips_errcnt_rst = r_errcnt_rst;
    assign compout_errcnt_rst    = r_errcnt_rst;
    assign busy                  = r_busy;
    assign done                  = r_done;
    assign timeout_err           = r_timeout_err;
    assign result_valid          = r_result_valid;
    assign result_strip          = r_result_strip;
    assign result_hs_errs        = r_result_hs;
    assign result_co_errs        = r_result_co;

endmodule

`default_nettype wire

// File: tb/tb_comparator_scan_sequencer.sv
// ============================================================================
// Module      : tb_comparator_scan_sequencer
// Description : Scoreboard bench with a behavioural comparator_injector model
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_comparator_scan_sequencer;

    localparam int PULSE_LEN = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] num_pulses = '0;
    logic [4:0]  first_strip = '0;
    logic [4:0]  last_strip = '0;
    logic        inject_en = 1'b0;
    logic        pulser_ready = 1'b1;
    logic [31:0] hs_err_val = '0;
    logic [31:0] co_err_val = '0;

    logic        fire_pulse;
    logic [31:0] halfstrips_expect;
    logic        compout_expect;
    logic        compin_inject;
    logic        halfstrips_errcnt_rst;
    logic        compout_errcnt_rst;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic        result_valid;
    logic [4:0]  result_strip;
    logic [15:0] result_hs_errs;
    logic [15:0] result_co_errs;

    always #5 clk = ~clk;

    comparator_scan_sequencer dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .abort                 (abort),
        .num_pulses            (num_pulses),
        .first_strip           (first_strip),
        .last_strip            (last_strip),
        .inject_en             (inject_en),
        .pulser_ready          (pulser_ready),
        .halfstrips_errcnt     (hs_err_val),
        .compout_errcnt        (co_err_val),
        .fire_pulse            (fire_pulse),
        .halfstrips_expect     (halfstrips_expect),
        .compout_expect        (compout_expect),
        .compin_inject         (compin_inject),
        .halfstrips_errcnt_rst (halfstrips_errcnt_rst),
        .compout_errcnt_rst    (compout_errcnt_rst),
        .busy                  (busy),
        .done                  (done),
        .timeout_err           (timeout_err),
        .result_valid          (result_valid),
        .result_strip          (result_strip),
        .result_hs_errs        (result_hs_errs),
        .result_co_errs        (result_co_errs)
    );

    // Injector: ready drops on fire and returns after PULSE_LEN cycles unless stalled.
    logic m_busy = 1'b0;
    int   m_cnt = 0;
    logic m_stall = 1'b0;

    always @(posedge clk) begin
        if (!m_busy) begin
            if (fire_pulse) begin
                m_busy       <= 1'b1;
                m_cnt        <= 0;
                pulser_ready <= 1'b0;
            end
        end else if (!m_stall) begin
            if (m_cnt == PULSE_LEN - 1) begin
                m_busy       <= 1'b0;
                pulser_ready <= 1'b1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    typedef struct {
        logic [4:0]  strip;
        logic [15:0] hs;
        logic [15:0] co;
        int          np;
        logic        inj;
    } exp_t;

    exp_t sb_q[$];

    logic exp_tmo = 1'b0;
    int   req_cnt = 0;
    int   req_kind = 0;
    int   hang_cnt = 0;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   mon_cyc = 0;
    int   last_res_cyc = -100;
    int   last_fire_cyc = 0;
    int   fires = 0;
    logic saw_rst = 1'b0;
    int   seen_req = 0;
    int   seen_hang = 0;
    exp_t mon_e;

    function void chk(input string name, input logic [95:0] act, input logic [95:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, mon_cyc);
        end
    endfunction

    always @(negedge clk) begin
        mon_cyc++;
        if (halfstrips_errcnt_rst) begin
            chk("errcnt_rst_pair", compout_errcnt_rst, 1'b1);
            saw_rst = 1'b1;
            fires   = 0;
        end
        if (fire_pulse) begin
            if (fires == 0) chk("errcnt_rst_before_fire", saw_rst, 1'b1);
            fires++;
            last_fire_cyc = mon_cyc;
        end
        if (result_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: actual strip=%0d required no result", result_strip);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result_strip", result_strip, mon_e.strip);
                chk("result_hs_errs", result_hs_errs, mon_e.hs);
                chk("result_co_errs", result_co_errs, mon_e.co);
                chk("fire_count", fires, mon_e.np);
                chk("halfstrips_expect", halfstrips_expect, 32'd1 << mon_e.strip);
                chk("compin_inject", compin_inject, mon_e.inj);
                chk("compout_expect", compout_expect, mon_e.inj);
            end
            last_res_cyc = mon_cyc;
            saw_rst      = 1'b0;
        end
        if (done) begin
            chk("done_timeout_err", timeout_err, exp_tmo);
            chk("results_outstanding", sb_q.size(), 0);
            if (exp_tmo) begin
                chk("timeout_latency", ((mon_cyc - last_fire_cyc) >= 256) && ((mon_cyc - last_fire_cyc) <= 260), 1'b1);
            end else begin
                chk("done_after_result", mon_cyc - last_res_cyc, 1);
            end
        end
        if (req_cnt != seen_req) begin
            seen_req = req_cnt;
            if (req_kind == 0) begin
                chk("outputs_zero_flags", {fire_pulse, compout_expect, compin_inject, halfstrips_errcnt_rst,
                                           compout_errcnt_rst, busy, done, timeout_err, result_valid, result_strip}, 0);
                chk("outputs_zero_data", {halfstrips_expect, result_hs_errs, result_co_errs}, 0);
            end else begin
                chk("timeout_err_cleared", timeout_err, 1'b0);
            end
        end
        if (hang_cnt != seen_hang) begin
            seen_hang = hang_cnt;
            n_cmp++;
            n_fail++;
            $display("FAIL wait_bound: actual=expired required=DUT event within budget");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int s, input int hs, input int co, input int np, input logic inj);
        exp_t x;
        x.strip = s[4:0];
        x.hs    = hs[15:0];
        x.co    = co[15:0];
        x.np    = np;
        x.inj   = inj;
        sb_q.push_back(x);
    endtask

    task automatic start_scan(input int f, input int l, input int np, input logic inj);
        first_strip = f[4:0];
        last_strip  = l[4:0];
        num_pulses  = np[15:0];
        inject_en   = inj;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 4000 && !done; k++) tick();
        if (!done) hang_cnt++;
        tick();
    endtask

    task automatic req(input int kind);
        req_kind = kind;
        req_cnt++;
        tick();
    endtask

    initial begin
        int k;
        rst = 1'b1;
        repeat (3) tick();
        req(0);
        rst = 1'b0;
        tick();

        // Single strip, three pulses
        hs_err_val = 32'd2; co_err_val = 32'd0;
        push(5, 2, 0, 3, 1'b1);
        start_scan(5, 5, 3, 1'b1);
        wait_done();

        // Sweep 0..3 with a start pulse while busy that must be ignored
        hs_err_val = 32'd1; co_err_val = 32'd4;
        for (int s = 0; s < 4; s++) push(s, 1, 4, 1, 1'b0);
        start_scan(0, 3, 1, 1'b0);
        repeat (5) tick();
        first_strip = 5'd20; last_strip = 5'd20; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();

        // num_pulses=0 behaves as one pulse
        push(7, 1, 4, 1, 1'b1);
        push(8, 1, 4, 1, 1'b1);
        start_scan(7, 8, 0, 1'b1);
        wait_done();

        // first > last covers first only
        push(10, 1, 4, 2, 1'b0);
        start_scan(10, 4, 2, 1'b0);
        wait_done();

        // Top strip terminates without wrapping
        push(30, 1, 4, 1, 1'b0);
        push(31, 1, 4, 1, 1'b0);
        start_scan(30, 31, 1, 1'b0);
        wait_done();
        repeat (30) tick();

        // Saturation
        hs_err_val = 32'h0001_2345; co_err_val = 32'd7;
        push(12, 16'hFFFF, 7, 1, 1'b1);
        start_scan(12, 12, 1, 1'b1);
        wait_done();
        hs_err_val = 32'h0000_FFFE; co_err_val = 32'h0001_0000;
        push(13, 16'hFFFE, 16'hFFFF, 2, 1'b0);
        start_scan(13, 13, 2, 1'b0);
        wait_done();

        // Timeout: injector never returns ready
        hs_err_val = 32'd0; co_err_val = 32'd0;
        m_stall = 1'b1;
        exp_tmo = 1'b1;
        start_scan(3, 3, 1, 1'b0);
        wait_done();
        m_stall = 1'b0;
        repeat (10) tick();
        exp_tmo = 1'b0;
        push(4, 0, 0, 1, 1'b0);
        start_scan(4, 4, 1, 1'b0);
        req(1);
        wait_done();

        // Abort during strip 2's pulse: strip 2 still reported
        hs_err_val = 32'd3; co_err_val = 32'd1;
        for (int s = 0; s < 3; s++) push(s, 3, 1, 2, 1'b1);
        start_scan(0, 5, 2, 1'b1);
        for (k = 0; k < 2000; k++) begin
            if (halfstrips_expect == 32'h4 && !pulser_ready) break;
            tick();
        end
        if (k == 2000) hang_cnt++;
        abort = 1'b1;
        wait_done();
        abort = 1'b0;

        // Reset in WAIT_ACK: no result expected from this scan
        hs_err_val = 32'd0; co_err_val = 32'd0;
        start_scan(6, 6, 3, 1'b0);
        for (k = 0; k < 200 && !fire_pulse; k++) tick();
        if (!fire_pulse) hang_cnt++;
        tick();
        rst = 1'b1;
        tick();
        req(0);
        rst = 1'b0;
        repeat (15) tick();

        // Recovery after reset
        push(1, 0, 0, 1, 1'b0);
        start_scan(1, 1, 1, 1'b0);
        wait_done();
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
